// File: rtl/uc_ctrl.sv
// uc_ctrl: instruction decode plus run/step/halt sequencer and retired-instruction counter.
// Optional feature macro: UC_CTRL_ILLEGAL_TRAP_EN (reserved opcodes halt the core and raise illegal).
module uc_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             z,
   input  logic             run,
   input  logic             step,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       op,
   output logic             pc_en,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CL_ALU  = 3'd0,
      CL_LI   = 3'd1,
      CL_J    = 3'd2,
      CL_JZ   = 3'd3,
      CL_JNZ  = 3'd4,
      CL_HALT = 3'd5,
      CL_RSVD = 3'd6
   } iclass_t;

   // ALU and LI classes ignore opcode[1:0]; those bits belong to operand fields.
   function automatic iclass_t classify(input logic [5:0] opc);
      iclass_t cls;
      if (opc[5]) begin
         cls = CL_ALU;
      end else begin
         case (opc[4:2])
            3'b000: begin
               case (opc[1:0])
                  2'b00:   cls = CL_J;
                  2'b01:   cls = CL_JZ;
                  2'b10:   cls = CL_JNZ;
                  default: cls = CL_HALT;
               endcase
            end
            3'b001:  cls = CL_LI;
            default: cls = CL_RSVD;
         endcase
      end
      return cls;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   iclass_t           iclass_s;
   logic              exec_s;
   logic              is_halt_s;
   logic              trap_s;
   logic              stop_s;
   logic              retire_s;
   logic              halted_r;
   logic [CNT_W-1:0]  retired_r;

   assign iclass_s  = classify(opcode);
   assign exec_s    = (state_r == ST_RUN) || (state_r == ST_STEP);
   assign is_halt_s = exec_s && (iclass_s == CL_HALT);

`ifdef UC_CTRL_ILLEGAL_TRAP_EN
   assign trap_s = exec_s && (iclass_s == CL_RSVD);
`else
   assign trap_s = 1'b0;
`endif

   assign stop_s   = is_halt_s || trap_s;
   assign retire_s = exec_s && !stop_s;

   // Combinational decode; everything is forced idle when not executing.
   always_comb begin
      s_inc = 1'b0;
      s_inm = 1'b0;
      we3   = 1'b0;
      wez   = 1'b0;
      op    = 3'b000;
      pc_en = 1'b0;
      if (exec_s) begin
         case (iclass_s)
            CL_ALU: begin
               op    = opcode[4:2];
               we3   = 1'b1;
               wez   = 1'b1;
               pc_en = 1'b1;
            end
            CL_LI: begin
               we3   = 1'b1;
               s_inm = 1'b1;
               pc_en = 1'b1;
            end
            CL_J: begin
               s_inc = 1'b1;
               pc_en = 1'b1;
            end
            CL_JZ: begin
               s_inc = z;
               pc_en = 1'b1;
            end
            CL_JNZ: begin
               s_inc = ~z;
               pc_en = 1'b1;
            end
            CL_HALT: begin
               pc_en = 1'b0;
            end
            CL_RSVD: begin
`ifdef UC_CTRL_ILLEGAL_TRAP_EN
               pc_en = 1'b0;
`else
               pc_en = 1'b1;
`endif
            end
            default: begin
               pc_en = 1'b0;
            end
         endcase
      end else begin
         pc_en = 1'b0;
      end
   end

   // Next-state selection; a retiring HALT or trap overrides the run/step controls.
   always_comb begin
      state_nxt_s = state_r;
      if (stop_s) begin
         state_nxt_s = ST_HALTED;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (run) begin
                  state_nxt_s = ST_RUN;
               end else if (step) begin
                  state_nxt_s = ST_STEP;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (run) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_STEP:   state_nxt_s = ST_IDLE;
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Sticky halted flag, set on the edge entering HALTED.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted_r <= 1'b0;
      end else if (stop_s) begin
         halted_r <= 1'b1;
      end else begin
         halted_r <= halted_r;
      end
   end

   // Retired-instruction counter, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_r <= {CNT_W{1'b0}};
      end else if (retire_s && (retired_r != {CNT_W{1'b1}})) begin
         retired_r <= retired_r + CNT_W'(1);
      end else begin
         retired_r <= retired_r;
      end
   end

`ifdef UC_CTRL_ILLEGAL_TRAP_EN
   logic illegal_r;

   // Trap flag, set together with halted when a reserved opcode stops the core.
   always_ff @(posedge clk) begin
      if (reset) begin
         illegal_r <= 1'b0;
      end else if (trap_s) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

   assign illegal = illegal_r;
`else
   assign illegal = 1'b0;
`endif

   assign halted  = halted_r;
   assign retired = retired_r;

endmodule

// File: tb/tb_uc_ctrl.sv
// Self-checking bench for uc_ctrl: behavioural model, directed plan steps, then random stimulus.
// Two instances (CNT_W = 16 and 4) share stimulus so counter saturation is covered.
module tb_uc_ctrl;

   logic        clk = 1'b0;
   logic        reset, run, step, z;
   logic [5:0]  opcode;

   logic        a_s_inc, a_s_inm, a_we3, a_wez, a_pc_en, a_halted, a_illegal;
   logic [2:0]  a_op;
   logic [15:0] a_retired;
   logic        b_s_inc, b_s_inm, b_we3, b_wez, b_pc_en, b_halted, b_illegal;
   logic [2:0]  b_op;
   logic [3:0]  b_retired;

   int checks = 0;
   int errors = 0;

   bit trap_en;
   bit m_running, m_single, m_stopped, m_halted, m_illegal;
   int m_ret16, m_ret4;

   always #5 clk = ~clk;

   uc_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .run(run), .step(step),
      .s_inc(a_s_inc), .s_inm(a_s_inm), .we3(a_we3), .wez(a_wez), .op(a_op),
      .pc_en(a_pc_en), .halted(a_halted), .illegal(a_illegal), .retired(a_retired)
   );

   uc_ctrl #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .run(run), .step(step),
      .s_inc(b_s_inc), .s_inm(b_s_inm), .we3(b_we3), .wez(b_wez), .op(b_op),
      .pc_en(b_pc_en), .halted(b_halted), .illegal(b_illegal), .retired(b_retired)
   );

   // 0 ALU, 1 LI, 2 J, 3 JZ, 4 JNZ, 5 HALT, 6 reserved
   function automatic int kind_of(input int opc);
      if (opc >= 32) return 0;
      if (opc < 4)   return 2 + opc;
      if (opc < 8)   return 1;
      return 6;
   endfunction

   // Expected {s_inc, s_inm, we3, wez, op, pc_en, halted, illegal}
   function automatic logic [9:0] exp_vec(input int opc, input bit zz);
      bit       inc, inm, w3, wz, pe;
      int       alu;
      int       k;
      inc = 0; inm = 0; w3 = 0; wz = 0; pe = 0; alu = 0;
      k = kind_of(opc);
      if (m_running || m_single) begin
         if (k == 0) begin alu = (opc / 4) % 8; w3 = 1; wz = 1; pe = 1; end
         if (k == 1) begin inm = 1; w3 = 1; pe = 1; end
         if (k == 2) begin inc = 1; pe = 1; end
         if (k == 3) begin inc = zz; pe = 1; end
         if (k == 4) begin inc = !zz; pe = 1; end
         if (k == 6) pe = !trap_en;
      end
      return {inc, inm, w3, wz, alu[2:0], pe, m_halted, m_illegal};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit rn, input bit st, input int opc);
      int  k;
      bit  ex, tr;
      k  = kind_of(opc);
      ex = m_running || m_single;
      tr = trap_en && (k == 6);
      if (r) begin
         m_running = 0; m_single = 0; m_stopped = 0;
         m_halted = 0; m_illegal = 0; m_ret16 = 0; m_ret4 = 0;
      end else if (ex && (k == 5 || tr)) begin
         m_running = 0; m_single = 0; m_stopped = 1; m_halted = 1;
         if (tr) m_illegal = 1;
      end else if (ex) begin
         if (m_ret16 < 65535) m_ret16++;
         if (m_ret4 < 15) m_ret4++;
         if (m_running) m_running = rn;
         else m_single = 0;
      end else if (!m_stopped) begin
         m_running = rn;
         m_single  = !rn && st;
      end
   endtask

   // One clock: drive, compare before the edge, advance the model at the edge.
   task automatic cycle(input bit r, input bit rn, input bit st, input logic [5:0] opc, input bit zz);
      reset = r; run = rn; step = st; opcode = opc; z = zz;
      #1;
      check("dec16", {a_s_inc, a_s_inm, a_we3, a_wez, a_op, a_pc_en, a_halted, a_illegal}, exp_vec(int'(opc), zz));
      check("dec4",  {b_s_inc, b_s_inm, b_we3, b_wez, b_op, b_pc_en, b_halted, b_illegal}, exp_vec(int'(opc), zz));
      check("ret16", a_retired, m_ret16);
      check("ret4",  b_retired, m_ret4);
      @(posedge clk);
      model_step(r, rn, st, int'(opc));
      @(negedge clk);
   endtask

   localparam logic [5:0] OP_ALU  = 6'b101000;
   localparam logic [5:0] OP_J    = 6'b000000;
   localparam logic [5:0] OP_JZ   = 6'b000001;
   localparam logic [5:0] OP_JNZ  = 6'b000010;
   localparam logic [5:0] OP_HALT = 6'b000011;
   localparam logic [5:0] OP_LI   = 6'b000110;
   localparam logic [5:0] OP_RSVD = 6'b001000;

   initial begin
`ifdef UC_CTRL_ILLEGAL_TRAP_EN
      trap_en = 1;
`else
      trap_en = 0;
`endif
      reset = 1'b1; run = 1'b0; step = 1'b0; z = 1'b0; opcode = 6'b100100;
      @(posedge clk);
      @(posedge clk);
      model_step(1, 0, 0, 0);
      @(negedge clk);

      // Reset state and idle with an ALU opcode present
      for (int i = 0; i < 10; i++) cycle(0, 0, 0, 6'b100100, 0);
      check("idle_ret", a_retired, 32'd0);
      check("idle_pc_en", a_pc_en, 32'd0);
      check("idle_we3", a_we3, 32'd0);

      // Run with ALU op: first RUN cycle decode, then count
      cycle(0, 1, 0, OP_ALU, 0);
      check("alu_op", a_op, 32'd2);
      check("alu_we3", a_we3, 32'd1);
      check("alu_wez", a_wez, 32'd1);
      check("alu_pc_en", a_pc_en, 32'd1);
      check("alu_s_inc", a_s_inc, 32'd0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, OP_ALU, 0);
      check("alu_ret5", a_retired, 32'd5);

      // Branches and LI
      cycle(0, 1, 0, OP_JZ, 1);  check("jz_z1", a_s_inc, 32'd1);
      cycle(0, 1, 0, OP_JNZ, 1); check("jnz_z1", a_s_inc, 32'd0);
      cycle(0, 1, 0, OP_JZ, 0);  check("jz_z0", a_s_inc, 32'd0);
      cycle(0, 1, 0, OP_JNZ, 0); check("jnz_z0", a_s_inc, 32'd1);
      cycle(0, 1, 0, OP_J, 0);   check("j_z0", a_s_inc, 32'd1);
      cycle(0, 1, 0, OP_J, 1);   check("j_z1", a_s_inc, 32'd1);
      cycle(0, 1, 0, OP_LI, 0);
      check("li_s_inm", a_s_inm, 32'd1);
      check("li_we3", a_we3, 32'd1);
      check("li_wez", a_wez, 32'd0);

      // run low still executes once, then single step with a repeated step ignored
      cycle(0, 0, 0, OP_ALU, 0);
      cycle(0, 0, 1, OP_ALU, 0);
      check("step_pc_en", a_pc_en, 32'd1);
      cycle(0, 0, 1, OP_ALU, 0);
      cycle(0, 0, 0, OP_ALU, 0);
      check("step_ret", a_retired, 32'd14);
      check("step_idle_pc_en", a_pc_en, 32'd0);

      // HALT is sticky until reset
      cycle(0, 1, 0, OP_ALU, 0);
      cycle(0, 1, 0, OP_ALU, 0);
      cycle(0, 1, 0, OP_HALT, 0);
      check("halt_flag", a_halted, 32'd1);
      check("halt_ret", a_retired, 32'd15);
      for (int i = 0; i < 6; i++)
         cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 0);
      check("halt_sticky_ret", a_retired, 32'd15);
      check("halt_sticky_flag", a_halted, 32'd1);
      cycle(1, 0, 0, OP_ALU, 0);
      check("rst_halted", a_halted, 32'd0);
      check("rst_ret", a_retired, 32'd0);

      // Reserved opcode
      cycle(0, 1, 0, OP_ALU, 0);
      cycle(0, 1, 0, OP_RSVD, 0);
`ifdef UC_CTRL_ILLEGAL_TRAP_EN
      check("rsvd_illegal", a_illegal, 32'd1);
      check("rsvd_halted", a_halted, 32'd1);
      check("rsvd_ret", a_retired, 32'd0);
`else
      check("rsvd_illegal", a_illegal, 32'd0);
      check("rsvd_ret", a_retired, 32'd1);
`endif

      // Saturation of the narrow counter
      cycle(1, 0, 0, OP_ALU, 0);
      cycle(0, 1, 0, OP_ALU, 0);
      for (int i = 0; i < 20; i++) cycle(0, 1, 0, OP_ALU, 0);
      check("sat4", b_retired, 32'hF);
      check("wide20", a_retired, 32'd20);

      // Random stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               6'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
